ll_tx_arbiter: RTL and testbench
================================

LL_TX_ARBITER -- requirements
Module: ll_tx_arbiter

Interface
REQ-001 SHALL have parameter HDRSIZE, default 49, header beats per frame.
REQ-002 SHALL have parameter DATALEN, default 1024, payload beats per frame.
REQ-003 SHALL have parameter CHAN_BYTE, default 0, header beat index replaced by the channel ID.
REQ-004 Port clk125MHz, input, 1, the single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1, reset; synchronous, active-high.
REQ-006 Port prog_full0 / prog_full1, input, 1 each, the source FIFO holds at least DATALEN bytes.
REQ-007 Port fifo_dout0 / fifo_dout1, input, 8 each, first-word-fall-through FIFO heads.
REQ-008 Port fifo_rd_en0 / fifo_rd_en1, output, 1 each, pop the FIFO head.
REQ-009 Port hdr_addr, output, 8, asynchronous-read header ROM address.
REQ-010 Port hdr_data, input, 8, header ROM data.
REQ-011 Port dst_rdyn, input, 1, active-low downstream ready.
REQ-012 Port sofn / eofn / src_rdyn, output, 1 each, active-low LocalLink framing.
REQ-013 Port data, output, 8, LocalLink data.
REQ-014 Port chan, output, 1, channel owning the current frame.
REQ-015 Port busy, output, 1, high while a frame is in progress.

Function
REQ-016 SHALL use the states IDLE, HDR, PAY and GAP.
REQ-017 A beat SHALL transfer in any cycle with src_rdyn==0 and dst_rdyn==0.
REQ-018 IDLE: if any prog_full is high, SHALL grant one channel and enter HDR on the next cycle.
  - Grant rule is round-robin: when both request, grant the channel not served last.
  - chan and the last-served pointer SHALL update at grant.
REQ-019 HDR/PAY: src_rdyn SHALL be 0, and a 16-bit beat counter SHALL increment per transfer.
REQ-020 sofn SHALL be 0 only on beat 0.
REQ-021 Header beat k SHALL present hdr_addr=k and data=hdr_data.
  - Exception: at k==CHAN_BYTE, data={7'b0,chan}.
REQ-022 PAY SHALL start at beat HDRSIZE.
  - data SHALL be the granted channel's fifo_dout.
  - That channel's fifo_rd_en SHALL equal the transfer condition; the other rd_en SHALL stay 0.
REQ-023 eofn SHALL be 0 only on beat HDRSIZE+DATALEN-1.
  - Transfer of that beat SHALL enter GAP and clear the counter.
REQ-024 GAP SHALL last exactly one cycle with src_rdyn=1, then return to IDLE.
  - Minimum frame-to-frame spacing is one idle cycle.
REQ-025 When dst_rdyn==1 in HDR/PAY, the block SHALL stall:
  - counter, hdr_addr, data, sofn and eofn held;
  - fifo_rd_en low.
REQ-026 Outside HDR/PAY: src_rdyn=1, sofn=1, eofn=1, fifo_rd_en*=0, hdr_addr=0, data=0.
REQ-027 prog_full changes after grant SHALL be ignored until the frame ends.
REQ-028 busy SHALL be high in HDR, PAY and GAP.
REQ-029 sofn/eofn/src_rdyn/busy/chan SHALL be registered; data, hdr_addr and fifo_rd_en* MAY be combinational from registered state.

Reset
REQ-030 rst SHALL take effect on the next rising edge, including mid-frame; the truncated frame is abandoned.
  - State returns to IDLE with counter 0 and last-served pointer 1, so channel 0 wins first.
  - chan=0, busy=0, and all outputs take their REQ-026 values.
REQ-031 No frame SHALL start in the cycle rst is high.

Configuration
REQ-032 Macro LL_BACKPRESSURE_EN:
  - Defined: dst_rdyn is honored per REQ-017/REQ-025.
  - Undefined: dst_rdyn is ignored and treated as 0; every HDR/PAY cycle is a transfer; the port remains present.

Structure
REQ-033 Shared package ll_pkg SHALL hold the state enumeration, the beat-counter width (16) and the LocalLink active-low level constants.
REQ-034 Sub-module ll_rr_arb SHALL implement the 2-way round-robin grant:
  - inputs: requests, last-served pointer, grant-enable;
  - outputs: grant valid, granted index.

Verification
REQ-035 Test: prog_full0=1 only, dst_rdyn=0.
  - SOF on beat 0 and beat CHAN_BYTE data=0x00.
  - Exactly 1024 fifo_rd_en0 pulses; EOF on beat 1072.
  - One-cycle gap; fifo_rd_en1 never high.
REQ-036 Test: prog_full0=prog_full1=1 held.
  - Frames alternate chan 0,1,0,1.
  - Each frame is 1073 beats with 1-cycle gaps.
REQ-037 Test: dst_rdyn=1 for 5 cycles at beat 10 and at beat 500.
  - Data and counter frozen while stalled; no rd_en pulses.
  - Frame still totals 1073 transfers; EOF unchanged.
REQ-038 Test: rst=1 for 1 cycle at beat 600 of a chan-1 frame.
  - Next cycle src_rdyn=1, busy=0.
  - With both requesting afterward, channel 0 is granted.
REQ-039 Test: prog_full1 drops at beat 20 of a chan-1 frame.
  - Frame completes with 1024 payload beats; next frame is chan 0 only.
REQ-040 Test: build with LL_BACKPRESSURE_EN undefined and dst_rdyn=1.
  - Frame transfers uninterrupted, with EOF at beat 1072.

Source files
------------

// File: rtl/ll_pkg.sv
// Shared LocalLink definitions: arbiter states, beat-counter width and the
// active-low framing levels.
package ll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    GAP  = 2'd3
  } ll_state_e;

  localparam int   CNT_W       = 16;
  localparam logic LL_ASSERT   = 1'b0;
  localparam logic LL_DEASSERT = 1'b1;

endpackage

// File: rtl/ll_rr_arb.sv
// Two-way round-robin grant: on a tie the channel not served last wins.
module ll_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Grant decode
  always_comb begin
    gnt_valid = en & (|req);
    if (req == 2'b11) begin
      gnt_idx = ~last;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/ll_tx_arbiter.sv
// Two-source LocalLink frame transmitter: header from ROM, payload from FIFOs.
// Optional macro LL_BACKPRESSURE_EN honours dst_rdyn; otherwise it is ignored.
module ll_tx_arbiter
  import ll_pkg::*;
#(
  parameter int HDRSIZE   = 49,
  parameter int DATALEN   = 1024,
  parameter int CHAN_BYTE = 0
) (
  input  logic       clk125MHz,
  input  logic       rst,
  input  logic       prog_full0,
  input  logic       prog_full1,
  input  logic [7:0] fifo_dout0,
  input  logic [7:0] fifo_dout1,
  output logic       fifo_rd_en0,
  output logic       fifo_rd_en1,
  output logic [7:0] hdr_addr,
  input  logic [7:0] hdr_data,
  input  logic       dst_rdyn,
  output logic       sofn,
  output logic       eofn,
  output logic       src_rdyn,
  output logic [7:0] data,
  output logic       chan,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDRSIZE - 1);
  localparam logic [CNT_W-1:0] EOF_BEAT  = CNT_W'(HDRSIZE + DATALEN - 1);
  localparam logic [CNT_W-1:0] CHAN_BEAT = CNT_W'(CHAN_BYTE);

  ll_state_e        state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             chan_r, chan_n;
  logic             last_r, last_n;
  logic             sofn_r, eofn_r, src_rdyn_r, busy_r;
  logic             stall, in_frame, xfer, next_in_frame;
  logic             gnt_valid, gnt_idx;

`ifdef LL_BACKPRESSURE_EN
  assign stall = dst_rdyn;
`else
  logic unused_dst_rdyn;
  assign unused_dst_rdyn = dst_rdyn;
  assign stall           = 1'b0;
`endif

  assign in_frame = (state_r == HDR) || (state_r == PAY);
  assign xfer     = in_frame & ~stall;

  ll_rr_arb u_arb (
    .req       ({prog_full1, prog_full0}),
    .last      (last_r),
    .en        ((state_r == IDLE) & ~rst),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Next-state and beat-counter logic
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    chan_n  = chan_r;
    last_n  = last_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid) begin
          state_n = HDR;
          cnt_n   = '0;
          chan_n  = gnt_idx;
          last_n  = gnt_idx;
        end else begin
          state_n = IDLE;
        end
      end
      HDR: begin
        if (xfer) begin
          cnt_n   = cnt_r + 16'd1;
          state_n = (cnt_r == HDR_LAST) ? PAY : HDR;
        end else begin
          state_n = HDR;
        end
      end
      PAY: begin
        if (xfer && (cnt_r == EOF_BEAT)) begin
          state_n = GAP;
          cnt_n   = '0;
        end else if (xfer) begin
          cnt_n   = cnt_r + 16'd1;
        end else begin
          state_n = PAY;
        end
      end
      GAP:     state_n = IDLE;
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign next_in_frame = (state_n == HDR) || (state_n == PAY);

  // Framing flags are computed from the next state so they line up with the beat
  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      chan_r     <= 1'b0;
      last_r     <= 1'b1;
      sofn_r     <= LL_DEASSERT;
      eofn_r     <= LL_DEASSERT;
      src_rdyn_r <= LL_DEASSERT;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      chan_r     <= chan_n;
      last_r     <= last_n;
      src_rdyn_r <= next_in_frame ? LL_ASSERT : LL_DEASSERT;
      sofn_r     <= (next_in_frame && (cnt_n == '0)) ? LL_ASSERT : LL_DEASSERT;
      eofn_r     <= (next_in_frame && (cnt_n == EOF_BEAT)) ? LL_ASSERT : LL_DEASSERT;
      busy_r     <= (state_n != IDLE);
    end
  end

  // Data path and FIFO pops
  always_comb begin
    hdr_addr    = 8'd0;
    data        = 8'd0;
    fifo_rd_en0 = 1'b0;
    fifo_rd_en1 = 1'b0;
    case (state_r)
      HDR: begin
        hdr_addr = cnt_r[7:0];
        data     = (cnt_r == CHAN_BEAT) ? {7'b0, chan_r} : hdr_data;
      end
      PAY: begin
        data        = chan_r ? fifo_dout1 : fifo_dout0;
        fifo_rd_en0 = xfer & ~chan_r;
        fifo_rd_en1 = xfer & chan_r;
      end
      default: begin
        hdr_addr = 8'd0;
        data     = 8'd0;
      end
    endcase
  end

  assign sofn     = sofn_r;
  assign eofn     = eofn_r;
  assign src_rdyn = src_rdyn_r;
  assign busy     = busy_r;
  assign chan     = chan_r;

endmodule

// File: tb/tb_ll_tx_arbiter.sv
// Randomized bench for ll_tx_arbiter against a frame-position reference model.
module tb_ll_tx_arbiter;

  localparam int H  = 49;
  localparam int D  = 1024;
  localparam int CB = 0;
  localparam int L  = H + D;
`ifdef LL_BACKPRESSURE_EN
  localparam int BP = 1;
`else
  localparam int BP = 0;
`endif

  logic       clk125MHz = 1'b0;
  logic       rst, prog_full0, prog_full1, dst_rdyn;
  logic [7:0] fifo_dout0, fifo_dout1, hdr_addr, hdr_data, data;
  logic       fifo_rd_en0, fifo_rd_en1, sofn, eofn, src_rdyn, chan, busy;

  logic [7:0] mem0 [512];
  logic [7:0] mem1 [512];
  logic [8:0] p0 = 9'd0;
  logic [8:0] p1 = 9'd0;

  int total = 0, bad = 0;
  int m_pos = -1, m_chan = 0, m_last = 1, mvalid = 0, e0 = 0, e1 = 0;
  int obs_rd0 = 0, obs_rd1 = 0, obs_beats = 0, obs_frames = 0;
  int obs_chans[$];

  ll_tx_arbiter #(.HDRSIZE(H), .DATALEN(D), .CHAN_BYTE(CB)) dut (
    .clk125MHz (clk125MHz), .rst (rst),
    .prog_full0 (prog_full0), .prog_full1 (prog_full1),
    .fifo_dout0 (fifo_dout0), .fifo_dout1 (fifo_dout1),
    .fifo_rd_en0 (fifo_rd_en0), .fifo_rd_en1 (fifo_rd_en1),
    .hdr_addr (hdr_addr), .hdr_data (hdr_data), .dst_rdyn (dst_rdyn),
    .sofn (sofn), .eofn (eofn), .src_rdyn (src_rdyn),
    .data (data), .chan (chan), .busy (busy)
  );

  always #4 clk125MHz = ~clk125MHz;

  function automatic logic [7:0] rom(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  always_comb hdr_data = rom(hdr_addr);
  assign fifo_dout0 = mem0[p0];
  assign fifo_dout1 = mem1[p1];

  // First-word-fall-through FIFO read pointers driven by the DUT pops
  always @(posedge clk125MHz) begin
    if (fifo_rd_en0) p0 <= p0 + 9'd1;
    if (fifo_rd_en1) p1 <= p1 + 9'd1;
  end

  task automatic chk_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input int xf);
    int in_f, hdr, pay, ed;
    in_f = (m_pos >= 0 && m_pos < L) ? 1 : 0;
    hdr  = (in_f == 1 && m_pos < H) ? 1 : 0;
    pay  = (in_f == 1 && m_pos >= H) ? 1 : 0;
    if (hdr == 1)      ed = (m_pos == CB) ? m_chan : int'(rom(8'(m_pos)));
    else if (pay == 1) ed = (m_chan == 1) ? int'(mem1[e1 % 512]) : int'(mem0[e0 % 512]);
    else               ed = 0;
    chk_val("src_rdyn", 32'(src_rdyn), (in_f == 1) ? 0 : 1);
    chk_val("sofn", 32'(sofn), (m_pos == 0) ? 0 : 1);
    chk_val("eofn", 32'(eofn), (m_pos == L - 1) ? 0 : 1);
    chk_val("busy", 32'(busy), (m_pos >= 0) ? 1 : 0);
    chk_val("chan", 32'(chan), m_chan);
    chk_val("data", 32'(data), ed);
    if (pay == 0) chk_val("hdr_addr", 32'(hdr_addr), (hdr == 1) ? m_pos : 0);
    chk_val("rd_en0", 32'(fifo_rd_en0), (pay == 1 && xf == 1 && m_chan == 0) ? 1 : 0);
    chk_val("rd_en1", 32'(fifo_rd_en1), (pay == 1 && xf == 1 && m_chan == 1) ? 1 : 0);
  endtask

  // One clock: check this cycle, record framing, advance the model, tick
  task automatic step();
    int xf;
    #1;
    xf = (BP == 1 && dst_rdyn == 1'b1) ? 0 : 1;
    if (mvalid == 1) compare_all(xf);
    if (fifo_rd_en0) obs_rd0++;
    if (fifo_rd_en1) obs_rd1++;
    if (src_rdyn == 1'b0 && xf == 1) begin
      if (sofn == 1'b0) begin
        obs_beats = 0;
        obs_chans.push_back(int'(chan));
      end
      if (eofn == 1'b0) begin
        chk_val("eof_beat", obs_beats, L - 1);
        obs_frames++;
      end
      obs_beats++;
    end
    if (mvalid == 1 && xf == 1 && m_pos >= H && m_pos < L) begin
      if (m_chan == 1) e1++;
      else             e0++;
    end
    if (rst) begin
      m_pos = -1; m_chan = 0; m_last = 1; mvalid = 1;
    end else if (mvalid == 0) begin
      m_pos = -1;
    end else if (m_pos < 0) begin
      if (prog_full0 || prog_full1) begin
        m_chan = (prog_full0 && prog_full1) ? 1 - m_last : (prog_full1 ? 1 : 0);
        m_last = m_chan;
        m_pos  = 0;
      end
    end else if (m_pos == L) begin
      m_pos = -1;
    end else if (xf == 1) begin
      m_pos++;
    end
    @(posedge clk125MHz);
    @(negedge clk125MHz);
  endtask

  task automatic wait_pos(input int target, input int budget, input string tag);
    int n = 0;
    while (m_pos != target && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk_val(tag, m_pos, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
    rst = 1'b1; prog_full0 = 1'b0; prog_full1 = 1'b0; dst_rdyn = 1'b0;
    @(negedge clk125MHz);
    do_reset();
    chk_val("rst_src_rdyn", 32'(src_rdyn), 1);
    chk_val("rst_sofn", 32'(sofn), 1);
    chk_val("rst_eofn", 32'(eofn), 1);
    chk_val("rst_busy", 32'(busy), 0);
    chk_val("rst_chan", 32'(chan), 0);
    chk_val("rst_data", 32'(data), 0);
    step();

    // Single channel 0 frame
    obs_rd0 = 0; obs_rd1 = 0;
    prog_full0 = 1'b1;
    wait_pos(0, 10, "s1_start");
    prog_full0 = 1'b0;
    wait_pos(-1, 2000, "s1_end");
    chk_val("s1_rd0_pulses", obs_rd0, D);
    chk_val("s1_rd1_pulses", obs_rd1, 0);
    chk_val("s1_chan_byte", 32'(mem0[0]) * 0 + int'(obs_chans[obs_chans.size() - 1]), 0);
    step();

    // Both requesting: alternation from a fresh reset
    do_reset();
    obs_chans.delete();
    obs_frames = 0;
    prog_full0 = 1'b1; prog_full1 = 1'b1;
    for (int n = 0; n < 6000 && obs_frames < 4; n++) step();
    prog_full0 = 1'b0; prog_full1 = 1'b0;
    wait_pos(-1, 2000, "s2_end");
    chk_val("s2_frames", obs_frames, 4);
    for (int i = 0; i < 4 && i < obs_chans.size(); i++) chk_val("s2_alt", obs_chans[i], i % 2);

    // Backpressure at beats 10 and 500
    obs_rd0 = 0;
    prog_full0 = 1'b1;
    wait_pos(0, 10, "s3_start");
    prog_full0 = 1'b0;
    wait_pos(10, 100, "s3_b10");
    dst_rdyn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    dst_rdyn = 1'b0;
    wait_pos(500, 1000, "s3_b500");
    dst_rdyn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    dst_rdyn = 1'b0;
    wait_pos(-1, 2000, "s3_end");
    chk_val("s3_rd0_pulses", obs_rd0, D);
    chk_val("s3_beats", obs_beats, L);

    // prog_full1 drops mid-frame of a channel-1 frame
    obs_rd0 = 0; obs_rd1 = 0;
    prog_full0 = 1'b1; prog_full1 = 1'b1;
    wait_pos(20, 100, "s4_b20");
    chk_val("s4_chan1", 32'(chan), 1);
    prog_full1 = 1'b0;
    wait_pos(-1, 2000, "s4_end1");
    chk_val("s4_rd1_pulses", obs_rd1, D);
    wait_pos(0, 10, "s4_start2");
    step();
    chk_val("s4_chan0", 32'(chan), 0);
    prog_full0 = 1'b0;
    wait_pos(-1, 2000, "s4_end2");
    chk_val("s4_rd0_pulses", obs_rd0, D);

    // Reset at beat 600 of a channel-1 frame
    prog_full1 = 1'b1;
    wait_pos(600, 1000, "s5_b600");
    chk_val("s5_chan1", 32'(chan), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_val("s5_src_rdyn", 32'(src_rdyn), 1);
    chk_val("s5_busy", 32'(busy), 0);
    prog_full0 = 1'b1; prog_full1 = 1'b1;
    step();
    chk_val("s5_regrant_chan", 32'(chan), 0);
    chk_val("s5_regrant_sofn", 32'(sofn), 0);
    prog_full0 = 1'b0; prog_full1 = 1'b0;
    wait_pos(-1, 2000, "s5_end");

    // Randomized requests and backpressure
    for (int n = 0; n < 3000; n++) begin
      dst_rdyn   = ($urandom_range(3) == 0) ? 1'b1 : 1'b0;
      prog_full0 = 1'($urandom_range(1));
      prog_full1 = 1'($urandom_range(1));
      step();
    end
    prog_full0 = 1'b0; prog_full1 = 1'b0; dst_rdyn = 1'b0;
    wait_pos(-1, 3000, "s6_end");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
